// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory req/ack sequencing with timeout, pipeline
// freeze, and branch/jump redirect with younger-stage flushes.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mem_mem_read,
  input  logic             ex_mem_mem_write,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_jump,
  input  logic             ex_mem_alu_zero,
  input  logic [31:0]      ex_mem_branch_addr,
  input  logic [31:0]      ex_mem_jump_addr,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             stall,
  output logic             pc_src,
  output logic [31:0]      pc_target,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic memop;
  logic req_raw;
  logic timeout_hit;
  logic done;
  logic stall_raw;
  logic take;
  logic [31:0] target_raw;

  assign memop       = ex_mem_mem_read | ex_mem_mem_write;
  assign req_raw     = (state_q == IDLE && memop) || (state_q == ACCESS);
  assign timeout_hit = (state_q == ACCESS) && (wait_cnt_q == LAST_WAIT);
  assign done        = dmem_ack | timeout_hit;
  assign stall_raw   = req_raw & ~done;
  assign take        = ex_mem_jump | (ex_mem_branch & ex_mem_alu_zero);
  assign target_raw  = ex_mem_jump ? ex_mem_jump_addr : ex_mem_branch_addr;

  // Every output is held low while reset is asserted, including a pending request.
  always_comb begin
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    stall        = 1'b0;
    pc_src       = 1'b0;
    pc_target    = '0;
    mem_err      = 1'b0;
    stall_cycles = '0;
    if (!rst) begin
      dmem_req     = req_raw;
      dmem_we      = ex_mem_mem_write;
      stall        = stall_raw;
      pc_src       = take & ~stall_raw;
      pc_target    = target_raw;
      mem_err      = mem_err_q;
      stall_cycles = stall_cycles_q;
    end
  end

  assign if_flush = pc_src;
  assign id_flush = pc_src;
  assign ex_flush = pc_src;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    stall_cycles_d = stall_cycles_q;
    unique case (state_q)
      IDLE: begin
        if (memop && !dmem_ack) begin
          state_d    = ACCESS;
          wait_cnt_d = 8'd1;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
        end else if (timeout_hit) begin
          // Abandon the access; the instruction leaves MEM without retry.
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stall_raw && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wait_cnt_q     <= 8'd0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd = 1'b0, wr = 1'b0, br = 1'b0, jp = 1'b0, zf = 1'b0, ack = 1'b0;
  logic [31:0] baddr = '0, jaddr = '0;
  logic dmem_req, dmem_we, stall, pc_src, if_flush, id_flush, ex_flush, mem_err;
  logic [31:0] pc_target;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_mem_read(rd), .ex_mem_mem_write(wr),
    .ex_mem_branch(br), .ex_mem_jump(jp), .ex_mem_alu_zero(zf),
    .ex_mem_branch_addr(baddr), .ex_mem_jump_addr(jaddr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(ack),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  typedef struct {
    string            name;
    logic [2:0]       req_we_stall;
    logic [2:0]       flush;
    logic             pc_src;
    logic [31:0]      target;
    logic             err;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // One vector = one clock cycle: drive inputs just after the edge, queue expectations.
  task automatic vec(input string nm,
                     input logic r, input logic i_rd, input logic i_wr,
                     input logic i_br, input logic i_jp, input logic i_z, input logic i_ack,
                     input logic [31:0] i_ba, input logic [31:0] i_ja,
                     input logic e_req, input logic e_we, input logic e_stall,
                     input logic e_pc, input logic [31:0] e_tgt,
                     input logic e_err, input logic [CNT_W-1:0] e_sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rd = i_rd; wr = i_wr; br = i_br; jp = i_jp; zf = i_z; ack = i_ack;
    baddr = i_ba; jaddr = i_ja;
    e.name = nm;
    e.req_we_stall = {e_req, e_we, e_stall};
    e.flush = {3{e_pc}};
    e.pc_src = e_pc;
    e.target = e_tgt;
    e.err = e_err;
    e.sc = e_sc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({dmem_req, dmem_we, stall} !== e.req_we_stall ||
          {if_flush, id_flush, ex_flush} !== e.flush || pc_src !== e.pc_src ||
          pc_target !== e.target || mem_err !== e.err || stall_cycles !== e.sc) begin
        n_bad++;
        $display("FAIL %s: got req/we/stall=%b flush=%b pc_src=%b tgt=%h err=%b sc=%0d ; want req/we/stall=%b flush=%b pc_src=%b tgt=%h err=%b sc=%0d",
                 e.name, {dmem_req, dmem_we, stall}, {if_flush, id_flush, ex_flush},
                 pc_src, pc_target, mem_err, stall_cycles,
                 e.req_we_stall, e.flush, e.pc_src, e.target, e.err, e.sc);
      end else begin
        $display("ok   %s: req/we/stall=%b pc_src=%b tgt=%h err=%b sc=%0d",
                 e.name, {dmem_req, dmem_we, stall}, pc_src, pc_target, mem_err, stall_cycles);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        name            rst rd wr br jp z ack  baddr      jaddr        req we st pc target     err sc
    vec("rst_hold",          1, 1, 0, 1, 0, 1, 0, 32'h40,  32'h0,   0, 0, 0, 0, 32'h0,   0, 0);
    vec("rst_hold2",         1, 0, 1, 0, 1, 0, 1, 32'h40,  32'h80,  0, 0, 0, 0, 32'h0,   0, 0);
    vec("idle_mux",          0, 0, 0, 0, 0, 0, 0, 32'h44,  32'h0,   0, 0, 0, 0, 32'h44,  0, 0);
    vec("zw_load",           0, 1, 0, 0, 0, 0, 1, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   0, 0);
    vec("zw_after",          0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   0, 0);
    vec("st3_c1",            0, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 1, 1, 0, 32'h0,   0, 0);
    vec("st3_c2",            0, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 1, 1, 0, 32'h0,   0, 1);
    vec("st3_c3_ack",        0, 0, 1, 0, 0, 0, 1, 32'h0,   32'h0,   1, 1, 0, 0, 32'h0,   0, 2);
    vec("st3_after",         0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   0, 2);
    vec("b2b_ld1_wait",      0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   0, 2);
    vec("b2b_ld1_ack",       0, 1, 0, 0, 0, 0, 1, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   0, 3);
    vec("b2b_ld2_wait",      0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   0, 3);
    vec("b2b_ld2_ack",       0, 1, 0, 0, 0, 0, 1, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   0, 4);
    vec("b2b_after",         0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   0, 4);
    vec("to_c1",             0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   0, 4);
    vec("to_c2",             0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   0, 5);
    vec("to_c3",             0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   0, 6);
    vec("to_c4_abort",       0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   0, 7);
    vec("to_err_set",        0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   1, 7);
    vec("stray_ack",         0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   1, 7);
    vec("br_taken",          0, 0, 0, 1, 0, 1, 0, 32'h40,  32'h200, 0, 0, 0, 1, 32'h40,  1, 7);
    vec("br_after",          0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   1, 7);
    vec("jump_prio",         0, 0, 0, 1, 1, 0, 0, 32'h40,  32'h100, 0, 0, 0, 1, 32'h100, 1, 7);
    vec("br_not_taken",      0, 0, 0, 1, 0, 0, 0, 32'h80,  32'h100, 0, 0, 0, 0, 32'h80,  1, 7);
    vec("br_mem_wait",       0, 1, 0, 1, 0, 1, 0, 32'h60,  32'h0,   1, 0, 1, 0, 32'h60,  1, 7);
    vec("br_mem_ack",        0, 1, 0, 1, 0, 1, 1, 32'h60,  32'h0,   1, 0, 0, 1, 32'h60,  1, 8);
    vec("br_mem_after",      0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   1, 8);
    vec("sat_ld_c1",         0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 8);
    vec("sat_ld_c2",         0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 9);
    vec("sat_ld_c3",         0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 10);
    vec("sat_ld_abort",      0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   1, 11);
    vec("sat_st_c1",         0, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 1, 1, 0, 32'h0,   1, 11);
    vec("sat_st_c2",         0, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 1, 1, 0, 32'h0,   1, 12);
    vec("sat_st_c3",         0, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 1, 1, 0, 32'h0,   1, 13);
    vec("sat_st_abort",      0, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 1, 0, 0, 32'h0,   1, 14);
    vec("sat_c1",            0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 14);
    vec("sat_c2",            0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 15);
    vec("sat_hold",          0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 15);
    vec("sat_ack",           0, 1, 0, 0, 0, 0, 1, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   1, 15);
    vec("rma_c1",            0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 15);
    vec("rma_w1",            0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 15);
    vec("rma_w2",            0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0, 32'h0,   1, 15);
    vec("rma_rst",           1, 1, 0, 0, 0, 0, 1, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   0, 0);
    vec("rma_release",       0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   0, 0);
    vec("rw_both_wait",      0, 1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 1, 1, 0, 32'h0,   0, 0);
    vec("rw_both_ack",       0, 1, 1, 0, 0, 0, 1, 32'h0,   32'h0,   1, 1, 0, 0, 32'h0,   0, 1);
    vec("final_idle",        0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   0, 1);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
